// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and DM loads/stores onto one
// single-port fixed-latency memory. Each access runs IDLE -> ISSUE -> WAIT
// -> RESP, so one access completes every MEM_LAT+3 cycles.
// Optional feature: define ARB_FAIR_EN for alternating grants under
// contention; otherwise DM always wins over IF.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ownerDm;
    logic             isStore;
    logic             grantDm;

`ifdef ARB_FAIR_EN
    logic lastDm;

    // Under contention the port that was not served last wins
    always_comb begin
        grantDm = dm_req;
        if (dm_req && if_req) begin
            grantDm = ~lastDm;
        end
    end
`else
    // DM holds the older instruction, so it always wins contention
    assign grantDm = dm_req;
`endif

    // Stalls release in the ack cycle so the hazard logic can advance
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // Access sequencer with registered memory strobes, acks and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ownerDm   <= 1'b0;
            isStore   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_FAIR_EN
            lastDm    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        mem_en    <= 1'b1;
                        mem_we    <= grantDm & dm_we;
                        mem_addr  <= grantDm ? dm_addr : if_addr;
                        mem_wdata <= grantDm ? dm_wdata : '0;
                        ownerDm   <= grantDm;
                        isStore   <= grantDm & dm_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
`ifdef ARB_FAIR_EN
                        lastDm    <= grantDm;
`endif
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= CNT_LOAD;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (ownerDm) begin
                            // A store leaves the last load value in place
                            if (!isStore) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ack <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes the
// expected memory strobes and acks into queues, a negedge monitor pops
// and compares them. A second instance covers MEM_LAT=1.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } acc_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   nCmp = 0;
    int   nBad = 0;

    logic        ifReq, ifAck, ifStall, dmReq, dmWe, dmAck, dmStall;
    logic [31:0] ifAddr, ifRdata, dmAddr, dmWdata, dmRdata;
    logic        memEn, memWe, busy;
    logic [31:0] memAddr, memWdata, memRdata;

    logic        i1Req, i1Ack, i1Stall, d1Req, d1We, d1Ack, d1Stall;
    logic [31:0] i1Addr, i1Rdata, d1Addr, d1Wdata, d1Rdata;
    logic        mem1En, mem1We, busy1;
    logic [31:0] mem1Addr, mem1Wdata, mem1Rdata;

    acc_t        memQ[$];
    acc_t        ifQ[$];
    acc_t        dmQ[$];
    logic [31:0] mem [logic [31:0]];
    int          rdCycle = -100;
    logic [31:0] rdData = 32'h0;
    int          rd1Cycle = -100;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck), .if_stall(ifStall),
        .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
        .dm_rdata(dmRdata), .dm_ack(dmAck), .dm_stall(dmStall),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(i1Req), .if_addr(i1Addr), .if_rdata(i1Rdata), .if_ack(i1Ack), .if_stall(i1Stall),
        .dm_req(d1Req), .dm_we(d1We), .dm_addr(d1Addr), .dm_wdata(d1Wdata),
        .dm_rdata(d1Rdata), .dm_ack(d1Ack), .dm_stall(d1Stall),
        .mem_en(mem1En), .mem_we(mem1We), .mem_addr(mem1Addr), .mem_wdata(mem1Wdata),
        .mem_rdata(mem1Rdata), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: cycle %0d got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushMem(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
        acc_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = 32'h0; e.cyc = c;
        memQ.push_back(e);
    endtask

    task automatic pushAck(input bit isDm, input logic [31:0] rdata, input int c);
        acc_t e;
        e.we = 1'b0; e.addr = 32'h0; e.wdata = 32'h0; e.rdata = rdata; e.cyc = c;
        if (isDm) dmQ.push_back(e);
        else ifQ.push_back(e);
    endtask

    task automatic waitAck(input bit isDm);
        int n = 0;
        while (!(isDm ? dmAck : ifAck) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            nCmp++;
            nBad++;
            $display("FAIL ack_timeout: port %s got no ack within 20 cycles", isDm ? "DM" : "IF");
        end
    endtask

    // Memory read data appears only in the cycle the macro would return it
    initial begin
        memRdata  = 32'hDEADBEEF;
        mem1Rdata = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            #1;
            memRdata  = (cyc == rdCycle) ? rdData : 32'hDEADBEEF;
            mem1Rdata = (cyc == rd1Cycle) ? 32'hCAFE0040 : 32'hDEADBEEF;
        end
    end

    // Monitor: compares every strobe/ack against the scoreboard and models the memory
    always @(negedge clk) begin : monitor
        acc_t e;
        if (memEn) begin
            if (memQ.size() == 0) begin
                nCmp++; nBad++;
                $display("FAIL unexpected_mem_en: cycle %0d got mem_en=1 required 0", cyc);
            end else begin
                e = memQ.pop_front();
                check("mem_en_cycle", cyc, e.cyc);
                check("mem_we", {31'h0, memWe}, {31'h0, e.we});
                check("mem_addr", memAddr, e.addr);
                if (e.we) check("mem_wdata", memWdata, e.wdata);
            end
            if (memWe) mem[memAddr] = memWdata;
            else begin
                rdCycle = cyc + LAT;
                rdData  = mem.exists(memAddr) ? mem[memAddr] : 32'h0;
            end
        end
        if (ifAck) begin
            if (ifQ.size() == 0) begin
                nCmp++; nBad++;
                $display("FAIL unexpected_if_ack: cycle %0d got if_ack=1 required 0", cyc);
            end else begin
                e = ifQ.pop_front();
                check("if_ack_cycle", cyc, e.cyc);
                check("if_rdata", ifRdata, e.rdata);
            end
        end
        if (dmAck) begin
            if (dmQ.size() == 0) begin
                nCmp++; nBad++;
                $display("FAIL unexpected_dm_ack: cycle %0d got dm_ack=1 required 0", cyc);
            end else begin
                e = dmQ.pop_front();
                check("dm_ack_cycle", cyc, e.cyc);
                check("dm_rdata", dmRdata, e.rdata);
            end
        end
        if (mem1En) rd1Cycle = cyc + 1;
    end

    initial begin
        int t;
        mem[32'h10] = 32'h00221820;
        mem[32'h11] = 32'h8C0A0004;
        mem[32'h18] = 32'h01095020;
        mem[32'h20] = 32'h11111111;
        mem[32'h24] = 32'h22222222;
        rst = 1'b0;
        ifReq = 1'b1; ifAddr = 32'h0;
        dmReq = 1'b0; dmWe = 1'b0; dmAddr = 32'h0; dmWdata = 32'h0;
        i1Req = 1'b0; i1Addr = 32'h0;
        d1Req = 1'b0; d1We = 1'b0; d1Addr = 32'h0; d1Wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state; stalls follow the raw requests
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_en", {31'h0, memEn}, 32'h0);
        check("rst_mem_we", {31'h0, memWe}, 32'h0);
        check("rst_if_ack", {31'h0, ifAck}, 32'h0);
        check("rst_dm_ack", {31'h0, dmAck}, 32'h0);
        check("rst_mem_addr", memAddr, 32'h0);
        check("rst_if_rdata", ifRdata, 32'h0);
        check("rst_dm_rdata", dmRdata, 32'h0);
        check("rst_if_stall", {31'h0, ifStall}, 32'h1);
        check("rst_dm_stall", {31'h0, dmStall}, 32'h0);
        ifReq = 1'b0;
        rst = 1'b1;
        step();

        // Single IF fetch
        t = cyc;
        ifReq = 1'b1; ifAddr = 32'h10;
        pushMem(1'b0, 32'h10, 32'h0, t + 1);
        pushAck(1'b0, 32'h00221820, t + 4);
        #1;
        check("t1_if_stall_t", {31'h0, ifStall}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t1_if_stall", {31'h0, ifStall}, 32'h1);
            check("t1_busy", {31'h0, busy}, 32'h1);
        end
        step();
        check("t1_if_stall_ack", {31'h0, ifStall}, 32'h0);
        waitAck(1'b0);
        ifReq = 1'b0;
        step();
        check("t1_busy_idle", {31'h0, busy}, 32'h0);
        step();

        // Simultaneous IF and DM load: DM first
        t = cyc;
        ifReq = 1'b1; ifAddr = 32'h18;
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h11;
        pushMem(1'b0, 32'h11, 32'h0, t + 1);
        pushAck(1'b1, 32'h8C0A0004, t + 4);
        pushMem(1'b0, 32'h18, 32'h0, t + 6);
        pushAck(1'b0, 32'h01095020, t + 9);
        waitAck(1'b1);
        dmReq = 1'b0;
        waitAck(1'b0);
        ifReq = 1'b0;
        step(); step();

        // Store keeps the last load value on dm_rdata
        t = cyc;
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h14; dmWdata = 32'h3;
        pushMem(1'b1, 32'h14, 32'h3, t + 1);
        pushAck(1'b1, 32'h8C0A0004, t + 4);
        waitAck(1'b1);
        dmReq = 1'b0; dmWe = 1'b0;
        step(); step();

        // Read the stored word back through IF
        t = cyc;
        ifReq = 1'b1; ifAddr = 32'h14;
        pushMem(1'b0, 32'h14, 32'h0, t + 1);
        pushAck(1'b0, 32'h3, t + 4);
        waitAck(1'b0);
        ifReq = 1'b0;
        step(); step();

        // Continuous contention for four grants
        t = cyc;
        ifReq = 1'b1; ifAddr = 32'h20;
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h24;
`ifdef ARB_FAIR_EN
        pushMem(1'b0, 32'h24, 32'h0, t + 1);  pushAck(1'b1, 32'h22222222, t + 4);
        pushMem(1'b0, 32'h20, 32'h0, t + 6);  pushAck(1'b0, 32'h11111111, t + 9);
        pushMem(1'b0, 32'h24, 32'h0, t + 11); pushAck(1'b1, 32'h22222222, t + 14);
        pushMem(1'b0, 32'h20, 32'h0, t + 16); pushAck(1'b0, 32'h11111111, t + 19);
`else
        for (int g = 0; g < 4; g++) begin
            pushMem(1'b0, 32'h24, 32'h0, t + 1 + 5 * g);
            pushAck(1'b1, 32'h22222222, t + 4 + 5 * g);
        end
`endif
        for (int k = 1; k <= 19; k++) begin
            step();
`ifndef ARB_FAIR_EN
            check("t4_if_starve_stall", {31'h0, ifStall}, 32'h1);
`endif
        end
        ifReq = 1'b0; dmReq = 1'b0;
        step(); step();

        // Reset during WAIT abandons the access
        t = cyc;
        dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h10;
        pushMem(1'b0, 32'h10, 32'h0, t + 1);
        step(); step();
        rst = 1'b0;
        #1;
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_mem_en", {31'h0, memEn}, 32'h0);
        check("t5_dm_ack", {31'h0, dmAck}, 32'h0);
        check("t5_dm_stall", {31'h0, dmStall}, 32'h1);
        step(); step();
        check("t5_dm_ack_hold", {31'h0, dmAck}, 32'h0);
        rst = 1'b1;
        t = cyc;
        pushMem(1'b0, 32'h10, 32'h0, t + 1);
        pushAck(1'b1, 32'h00221820, t + 4);
        waitAck(1'b1);
        dmReq = 1'b0;
        step(); step();

        // MEM_LAT=1 instance: mem_en at t+1, ack at t+3
        t = cyc;
        i1Req = 1'b1; i1Addr = 32'h40;
        step();
        check("l1_mem_en", {31'h0, mem1En}, 32'h1);
        check("l1_mem_we", {31'h0, mem1We}, 32'h0);
        check("l1_mem_addr", mem1Addr, 32'h40);
        step();
        check("l1_mem_en_off", {31'h0, mem1En}, 32'h0);
        check("l1_ack_early", {31'h0, i1Ack}, 32'h0);
        step();
        check("l1_if_ack", {31'h0, i1Ack}, 32'h1);
        check("l1_if_rdata", i1Rdata, 32'hCAFE0040);
        check("l1_ack_cycle", cyc, t + 3);
        i1Req = 1'b0;
        step(); step();

        check("memq_drained", memQ.size(), 32'h0);
        check("ifq_drained", ifQ.size(), 32'h0);
        check("dmq_drained", dmQ.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
